ser_frame_ctrl: RTL

SER_FRAME_CTRL -- requirements
Module: ser_frame_ctrl

---
 rtl/ser_frame_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/ser_frame_ctrl.sv
// Serial frame controller: loads WIDTH-bit words and shifts them out LSB first,
// frame after frame, until a frame count is reached or stop is requested.
module ser_frame_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [7:0]       num_frames,
    input  logic [WIDTH-1:0] idle_pattern,
    input  logic [WIDTH-1:0] word_in,
    input  logic             word_valid,
    output logic             word_ready,
    output logic [WIDTH-1:0] shreg,
    output logic             ser_out,
    output logic             frame_strobe,
    output logic             busy,
    output logic             done,
    output logic [7:0]       underrun_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] bitcnt;
    logic [7:0]    frames_done;
    logic [7:0]    nf_lat;
    logic          stop_pending;
    logic          frame_end;
    logic          run_end;
    logic          count_end;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign count_end = (nf_lat != 8'd0) && ((frames_done + 8'd1) == nf_lat);
    assign ser_out   = shreg[0];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        word_ready   = 1'b0;
        frame_end    = 1'b0;
        run_end      = 1'b0;
        busy         = (state == RUN);
        frame_strobe = (state == RUN) && (bitcnt == '0);
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    state_nx   = RUN;
                    word_ready = 1'b1;
                end
            end
            RUN: begin
                if (bitcnt == LAST) begin
                    frame_end = 1'b1;
                    if (stop || stop_pending || count_end) begin
                        run_end  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        word_ready = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        // Reset blocks any transfer in the cycle it is asserted.
        if (rst) word_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            bitcnt       <= '0;
            frames_done  <= 8'd0;
            nf_lat       <= 8'd0;
            stop_pending <= 1'b0;
            underrun_cnt <= 8'd0;
            done         <= 1'b0;
        end else begin
            done <= frame_end && run_end && count_end;
            if (word_ready) begin
                if (word_valid) begin
                    shreg <= word_in;
                end else begin
                    shreg        <= idle_pattern;
                    underrun_cnt <= sat_inc8(underrun_cnt);
                end
            end
            if (state == IDLE) begin
                if (word_ready) begin
                    bitcnt       <= '0;
                    frames_done  <= 8'd0;
                    nf_lat       <= num_frames;
                    stop_pending <= 1'b0;
                end
            end else if (frame_end) begin
                bitcnt      <= '0;
                frames_done <= frames_done + 8'd1;
                if (run_end) begin
                    shreg        <= '0;
                    stop_pending <= 1'b0;
                end
            end else begin
                shreg  <= {shreg[0], shreg[WIDTH-1:1]};
                bitcnt <= bitcnt + CW'(1);
                if (stop) stop_pending <= 1'b1;
            end
        end
    end

endmodule
